// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES-128 encryption sequencer. One external round datapath and one
// external key expander are shared across all ten rounds. A plaintext/key pair
// is accepted on a valid/ready handshake. The initial AddRoundKey is applied on
// acceptance. Rounds 1-9 then run as full rounds. Round 10 runs as the final
// round without MixColumns. The ciphertext is held until the sink takes it.
//
// Parameter
//   RND_LAT     cycles the round datapath needs from stable rd_state/rd_key to a
//               valid rd_result (1..15)
//
// Ports
//   CLK         clock, rising edge
//   RST         asynchronous, active-high reset
//   in_valid    plaintext/key offered
//   in_ready    idle and able to accept
//   data_in     plaintext
//   key_in      cipher key
//   out_valid   ciphertext available
//   out_ready   sink accepts ciphertext
//   data_out    ciphertext (the state register)
//   rd_state    state presented to the round datapath
//   rd_final    1 = final round (no MixColumns)
//   rd_idx      current round 1..10, 0 when not running
//   rd_rcon     round constant for rd_idx, to the key expander
//   cipher_key  latched cipher key, to the key expander
//   rd_key      round key from the key expander (consumed by the datapath)
//   rd_result   round datapath output
//   abort       only when AES_CTRL_ABORT_EN is defined
//
// Build option
//   AES_CTRL_ABORT_EN  adds the abort input. A high abort in RUN or DONE
//                      returns the block to IDLE on the next edge.
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
   parameter int RND_LAT = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic [127:0] key_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic [127:0] rd_state,
   output logic         rd_final,
   output logic [3:0]   rd_idx,
   output logic [7:0]   rd_rcon,
   output logic [127:0] cipher_key,
   input  logic [127:0] rd_key,
`ifdef AES_CTRL_ABORT_EN
   input  logic [127:0] rd_result,
   input  logic         abort
`else
   input  logic [127:0] rd_result
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Last wait-counter value of a round window; rd_result is captured on the
   // edge that ends the window.
   localparam logic [3:0] WCNT_LAST = 4'(RND_LAT - 1);

   state_t       r_state;
   state_t       w_state_next;
   logic [127:0] r_data;
   logic [127:0] w_data_next;
   logic [127:0] r_key;
   logic [127:0] w_key_next;
   logic [3:0]   r_rnd;
   logic [3:0]   w_rnd_next;
   logic [7:0]   r_rcon;
   logic [7:0]   w_rcon_next;
   logic [3:0]   r_wcnt;
   logic [3:0]   w_wcnt_next;

   logic         w_run;
   logic         w_round_end;
   logic [7:0]   w_rcon_xtime;

   // The round key goes straight from the expander to the datapath. The
   // controller never inspects it.
   logic         w_unused_rd_key;
   assign w_unused_rd_key = ^rd_key;

   assign w_run        = (r_state == S_RUN);
   assign w_round_end  = (r_wcnt == WCNT_LAST);
   // GF(2^8) doubling. This produces the next round constant.
   assign w_rcon_xtime = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_key   <= '0;
         r_rnd   <= '0;
         r_rcon  <= '0;
         r_wcnt  <= '0;
      end else begin
         r_state <= w_state_next;
         r_data  <= w_data_next;
         r_key   <= w_key_next;
         r_rnd   <= w_rnd_next;
         r_rcon  <= w_rcon_next;
         r_wcnt  <= w_wcnt_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_data_next  = r_data;
      w_key_next   = r_key;
      w_rnd_next   = r_rnd;
      w_rcon_next  = r_rcon;
      w_wcnt_next  = r_wcnt;

      case (r_state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               w_data_next  = data_in ^ key_in;
               w_key_next   = key_in;
               w_rnd_next   = 4'd1;
               w_rcon_next  = 8'h01;
               w_wcnt_next  = 4'd0;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            w_wcnt_next = r_wcnt + 4'd1;
            if (w_round_end) begin
               w_data_next = rd_result;
               w_wcnt_next = 4'd0;
               if (r_rnd == 4'd10) begin
                  // Return the round bookkeeping to its idle values.
                  w_rnd_next   = 4'd0;
                  w_rcon_next  = 8'h00;
                  w_state_next = S_DONE;
               end else begin
                  w_rnd_next  = r_rnd + 4'd1;
                  w_rcon_next = w_rcon_xtime;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

`ifdef AES_CTRL_ABORT_EN
      // Abort overrides the round capture. A block in flight is discarded.
      if (abort && (r_state != S_IDLE)) begin
         w_state_next = S_IDLE;
         w_data_next  = r_data;
         w_key_next   = r_key;
         w_rnd_next   = 4'd0;
         w_rcon_next  = 8'h00;
         w_wcnt_next  = 4'd0;
      end
`endif
   end

   assign in_ready   = (r_state == S_IDLE) & ~RST;
   assign out_valid  = (r_state == S_DONE);
   assign data_out   = r_data;
   assign rd_state   = r_data;
   assign cipher_key = r_key;
   assign rd_idx     = w_run ? r_rnd  : 4'd0;
   assign rd_rcon    = w_run ? r_rcon : 8'h00;
   assign rd_final   = w_run & (r_rnd == 4'd10);

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative sequencer for AES-128 encryption that time-shares one external round datapath and one external key expander over all ten rounds. Accepts a plaintext/key pair on a valid/ready handshake, applies the initial AddRoundKey, and drives rounds 1–9 as full rounds and round 10 as the final round without MixColumns. Holds the ciphertext until the downstream sink takes it. Sits between the block-level I/O and the shared round datapath.

## Interface
- RND_LAT, 3, cycles the round datapath needs from a stable `rd_state`/`rd_key` to a valid `rd_result`; legal range 1–15
- CLK  in  1  single clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  controller idle and able to accept
- data_in  in  128  plaintext
- key_in  in  128  cipher key
- out_valid  out  1  ciphertext available
- out_ready  in  1  sink accepts ciphertext
- data_out  out  128  ciphertext (the state register)
- rd_state  out  128  state presented to the round datapath
- rd_final  out  1  1 = final round (no MixColumns), 0 = full round
- rd_idx  out  4  current round number, 1–10; 0 when not running
- rd_rcon  out  8  round constant for `rd_idx`, to the key expander
- cipher_key  out  128  latched cipher key, to the key expander
- rd_key  in  128  round key for `rd_idx`, from the key expander
- rd_result  in  128  round datapath output
- abort  in  1  present only with AES_CTRL_ABORT_EN

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`:
    - state_reg ← data_in ^ key_in
    - cipher_key ← key_in
    - rnd ← 1, rcon ← 8'h01, wcnt ← 0
    - go to RUN
- RUN:
  - `rd_state` = state_reg, `rd_idx` = rnd, `rd_rcon` = rcon, `rd_final` = (rnd == 10).
  - `rd_state`, `rd_idx`, `rd_rcon` and `rd_final` stay stable for the whole round window.
  - wcnt increments each cycle.
  - When wcnt == RND_LAT−1:
    - state_reg ← rd_result, wcnt ← 0
    - if rnd == 10, go to DONE
    - otherwise rnd ← rnd+1 and rcon ← xtime(rcon), where xtime = left shift, XOR 8'h1B on carry
- DONE:
  - `out_valid` = 1, `data_out` = state_reg, held stable until `out_ready`.
  - On `out_valid & out_ready`, go to IDLE.
- Arithmetic:
  - wcnt is 4 bits; rnd is 4 bits.
  - rcon sequence: 01,02,04,08,10,20,40,80,1B,36.
- Outside RUN: `rd_idx` = 0, `rd_final` = 0, `rd_rcon` = 8'h00. `rd_state` always equals state_reg.
- `in_ready` = (state == IDLE) & ~RST. `out_valid` = (state == DONE).
- Reset values: state_reg = 0, cipher_key = 0, rnd = 0, rcon = 0, wcnt = 0. Consequently `out_valid` = 0, `data_out` = 0, `rd_idx` = 0, `rd_rcon` = 0, `rd_final` = 0, `in_ready` = 0 while RST is high.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above; no partial ciphertext is ever flagged valid.
- `in_valid` in RUN/DONE is ignored (`in_ready` = 0); the source must hold it.
- DONE with `out_ready` high and `in_valid` high in the same cycle: output transfers, next input is accepted no earlier than the following cycle in IDLE.

## Timing
- Accept edge to `out_valid` rising: exactly 10·RND_LAT cycles (30 at default).
- Throughput: one block per 10·RND_LAT + 2 cycles when `out_ready` is held high.
- `rd_result` is sampled only on the edge ending each round window; the datapath is not required to be valid at any other time.
- `out_valid` is registered; there is no combinational path from `out_ready` to `in_ready`.

## Configuration
- AES_CTRL_ABORT_EN defined:
  - `abort` port exists.
  - `abort` high in RUN or DONE forces IDLE on the next edge and clears rnd/wcnt/rcon.
  - `out_valid` drops and no transfer is reported; abort has priority over round capture.
  - `abort` in IDLE has no effect and does not block acceptance.
- Not defined: port absent; a started block always runs to DONE.

## Test plan
- FIPS-197 C.1 vector (RND_LAT = 3, real datapath and expander):
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
  - Response: `data_out` = 69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` exactly 30 cycles after accept.
- Sequencing check against a stub datapath:
  - `rd_rcon` steps through 01…36 with `rd_idx` 1…10.
  - `rd_final` is high only during round 10.
  - Each round window is RND_LAT cycles with stable outputs.
- Backpressure:
  - Stimulus: `out_ready` low for 20 cycles in DONE while `in_valid` stays high.
  - Response: `data_out` stable, `in_ready` = 0; after `out_ready` pulses, the next block is accepted one cycle later.
- Reset mid-run:
  - Stimulus: assert RST during round 5.
  - Response: all outputs at reset values asynchronously, `in_ready` = 1 first cycle after release, no `out_valid`.
- RND_LAT = 1:
  - Response: back-to-back blocks complete with 10-cycle latency.
  - Response: the FIPS-197 result is unchanged.
- With AES_CTRL_ABORT_EN:
  - Stimulus: abort in round 7.
  - Response: IDLE next cycle, `out_valid` never asserted; a new block then completes correctly.
